// File: rtl/fetch_queue_stage_pkg.sv
// Shared constants and types for the RV32I fetch stage and its response queue.
package fetch_queue_stage_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// fetch_fifo: circular buffer of fetched words; entries are allocated at grant and filled in order.
// With FETCH_MISALIGN_EN a clear can also seed slot 0 with a pre-filled, flagged NOP.
module fetch_fifo
  import fetch_queue_stage_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int AW     = $clog2(QDEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        alloc_i,
  input  logic [31:0] alloc_pc_i,
  input  logic        fill_i,
  input  logic [31:0] fill_inst_i,
  input  logic        pop_i,
`ifdef FETCH_MISALIGN_EN
  input  logic        mis_push_i,
  input  logic [31:0] mis_pc_i,
  output logic        head_mis_o,
`endif
  output logic        full_o,
  output logic        head_filled_o,
  output fq_entry_t   head_o,
  output logic [AW:0] unfilled_o
);

  localparam logic [AW:0] PONE = 1;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0]             head_q, tail_q, fptr_q, count;
  logic [AW-1:0]           hidx, tidx, fidx;
  logic [QDEPTH-1:0][31:0] pc_q, inst_q;
  logic [QDEPTH-1:0]       filled_q;

  assign hidx          = head_q[AW-1:0];
  assign tidx          = tail_q[AW-1:0];
  assign fidx          = fptr_q[AW-1:0];
  assign count         = tail_q - head_q;
  assign full_o        = count[AW];
  assign unfilled_o    = tail_q - fptr_q;
  assign head_filled_o = (count != '0) && filled_q[hidx];
  assign head_o        = '{pc: pc_q[hidx], inst: inst_q[hidx]};

`ifdef FETCH_MISALIGN_EN
  logic [QDEPTH-1:0] mis_q;
  assign head_mis_o = mis_q[hidx];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      fptr_q   <= '0;
      pc_q     <= '0;
      inst_q   <= '0;
      filled_q <= '0;
`ifdef FETCH_MISALIGN_EN
      mis_q    <= '0;
`endif
    end else if (clear_i) begin
      head_q <= '0;
      tail_q <= '0;
      fptr_q <= '0;
`ifdef FETCH_MISALIGN_EN
      if (mis_push_i) begin
        pc_q[0]     <= mis_pc_i;
        inst_q[0]   <= NOP_INST;
        filled_q[0] <= 1'b1;
        mis_q[0]    <= 1'b1;
        tail_q      <= PONE;
        fptr_q      <= PONE;
      end
`endif
    end else begin
      if (alloc_i) begin
        pc_q[tidx]     <= alloc_pc_i;
        filled_q[tidx] <= 1'b0;
`ifdef FETCH_MISALIGN_EN
        mis_q[tidx]    <= 1'b0;
`endif
        tail_q         <= tail_q + PONE;
      end
      if (fill_i) begin
        inst_q[fidx]   <= fill_inst_i;
        filled_q[fidx] <= 1'b1;
        fptr_q         <= fptr_q + PONE;
      end
      if (pop_i) head_q <= head_q + PONE;
    end
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// RV32I fetch stage: PC generation, in-order imem requests, queued responses handed to decode.
// Optional FETCH_MISALIGN_EN: a misaligned redirect queues a flagged NOP and halts fetch.
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
`ifdef FETCH_MISALIGN_EN
  output logic        id_misalign,
`endif
  output logic [31:0] id_pc
);

  localparam int AW = $clog2(QDEPTH);
  localparam int DW = $clog2(2*QDEPTH+1);
  localparam logic [DW-1:0] DONE = 1;

  logic [31:0]   pc_q, pc_d;
  logic [DW-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]   id_pc_q;
  logic          run_q;
  logic          halt;
  logic [31:0]   redir_pc;
  logic          full, head_filled, pop, grant, fill;
  logic [AW:0]   unfilled;
  fq_entry_t     head;

`ifdef FETCH_MISALIGN_EN
  logic halt_q, redir_mis, head_mis;
  assign redir_pc    = redirect_pc;
  assign redir_mis   = |redirect_pc[1:0];
  assign halt        = halt_q;
  assign id_misalign = id_valid & head_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              halt_q <= 1'b0;
    else if (redirect_valid) halt_q <= redir_mis;
  end
`else
  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign halt     = 1'b0;
`endif

  assign id_valid  = head_filled;
  assign id_inst   = id_valid ? head.inst : NOP_INST;
  assign id_pc     = id_valid ? head.pc : id_pc_q;
  assign pop       = id_valid & id_ready & ~redirect_valid;
  // A pop frees the head slot in time for this cycle's grant to reuse it.
  assign imem_req  = run_q & ~redirect_valid & ~halt & (~full | pop);
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;
  assign fill      = imem_rvalid & (drop_cnt_q == '0) & ~redirect_valid;

  // On redirect every unfilled entry becomes a word to discard, less the one arriving now.
  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = redir_pc;
      drop_cnt_d = drop_cnt_q + DW'(unfilled) - DW'(imem_rvalid);
    end else begin
      if (grant) pc_d = pc_next(pc_q);
      if (imem_rvalid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
      id_pc_q    <= '0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
      run_q      <= 1'b1;
      if (id_valid) id_pc_q <= head.pc;
    end
  end

  fetch_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (redirect_valid),
    .alloc_i       (grant),
    .alloc_pc_i    (pc_q),
    .fill_i        (fill),
    .fill_inst_i   (imem_rdata),
    .pop_i         (pop),
`ifdef FETCH_MISALIGN_EN
    .mis_push_i    (redirect_valid & redir_mis),
    .mis_pc_i      (redirect_pc),
    .head_mis_o    (head_mis),
`endif
    .full_o        (full),
    .head_filled_o (head_filled),
    .head_o        (head),
    .unfilled_o    (unfilled)
  );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: in-order memory model with variable latency and a PC scoreboard.
module tb_fetch_queue_stage;
  import fetch_queue_stage_pkg::*;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] tgt; int lat; bit rnd; int n; } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_inst, id_pc;
`ifdef FETCH_MISALIGN_EN
  logic        id_misalign;
`endif

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int n_chk = 0, n_pass = 0, cyc = 0, lat = 1;
  int grant_cnt = 0, req_cnt = 0, acc_cnt = 0, first_acc = 0, last_acc = 0;
  bit rnd_ready = 1'b0;

  fetch_queue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
`ifdef FETCH_MISALIGN_EN
    .id_misalign(id_misalign),
`endif
    .id_pc(id_pc)
  );

  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Memory model and decode-side scoreboard, both working on the falling edge.
  initial begin
    mreq_t r;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (!rst_n) mem_q.delete();
      else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
      id_ready = (exp_q.size() > 0) && (!rnd_ready || $urandom_range(0, 3) != 0);
      #1;
      if (rst_n && imem_req && imem_gnt) begin
        r.addr = imem_addr;
        r.due  = cyc + lat;
        mem_q.push_back(r);
        grant_cnt++;
      end
      if (imem_req) req_cnt++;
      if (rst_n && id_valid && id_ready && !redirect_valid) begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e);
        chk("id_inst", id_inst, mem_word(e));
        if (acc_cnt == 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
      end
    end
  end

  task automatic push_path(input logic [31:0] tgt, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(tgt + 32'(4 * i));
  endtask

  task automatic redirect(input logic [31:0] tgt, input bit chk_next);
    @(posedge clk); #2;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    exp_q.delete();
    #1 chk("req_during_redirect", imem_req, 0);
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    #1;
    if (chk_next) begin
      chk("req_after_redirect", imem_req, 1);
      chk("addr_after_redirect", imem_addr, tgt);
    end
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic settle_drop();
    repeat (8) @(posedge clk);
    #1 chk("drop_cnt_zero", 32'(dut.drop_cnt_q), 0);
  endtask

  initial begin
    vec_t vt[5];
    int g0, r0;
    vt[0] = '{32'hFFFF_FFF8, 1, 1'b0, 4};
    vt[1] = '{32'h0000_1000, 2, 1'b1, 10};
    vt[2] = '{32'h0000_2000, 1, 1'b1, 12};
    vt[3] = '{32'h0000_3000, 3, 1'b0, 6};
    vt[4] = '{32'hFFFF_FFF0, 2, 1'b1, 8};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, RESET_PC_DEF);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_inst", id_inst, NOP_INST);

    // Streaming from reset with a 1-cycle memory: one instruction per cycle
    push_path(RESET_PC_DEF, 12);
    @(posedge clk); #2 rst_n = 1'b1;
    #1 chk("first_cycle_id_pc_hold", id_pc, 0);
    wait_drain(80);
    chk("stream_back_to_back", 32'(last_acc - first_acc), 11);

    // Decode stalled: exactly QDEPTH requests go out, then none while full
    redirect(32'h0000_0400, 1'b1);
    g0 = grant_cnt;
    repeat (8) @(posedge clk);
    #1 chk("stall_grants", 32'(grant_cnt - g0), 2);
    r0 = req_cnt;
    repeat (5) @(posedge clk);
    #1 chk("stall_no_req", 32'(req_cnt - r0), 0);
    push_path(32'h0000_0400, 6);
    wait_drain(60);

    // Redirect to 0x100 with requests in flight on a 3-cycle memory
    lat = 3;
    redirect(32'h0000_0080, 1'b1);
    push_path(32'h0000_0080, 40);
    repeat (6) @(posedge clk);
    redirect(32'h0000_0100, 1'b1);
    push_path(32'h0000_0100, 6);
    for (int i = 0; i < 3; i++) begin
      chk("drop_id_valid", id_valid, 0);
      chk("drop_id_inst", id_inst, NOP_INST);
      @(posedge clk); #3;
    end
    wait_drain(80);
    settle_drop();

    // Back-to-back redirects: only the second path is delivered
    lat = 2;
    @(posedge clk); #2;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; exp_q.delete();
    @(posedge clk); #2;
    redirect_pc = 32'h0000_0300;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    #1 chk("b2b_addr", imem_addr, 32'h0000_0300);
    push_path(32'h0000_0300, 6);
    wait_drain(80);
    settle_drop();

`ifdef FETCH_MISALIGN_EN
    // Misaligned redirect: flagged NOP at head, no fetch until the next redirect
    lat = 1;
    redirect(32'h0000_0102, 1'b0);
    @(posedge clk); #3;
    chk("mis_id_valid", id_valid, 1);
    chk("mis_flag", id_misalign, 1);
    chk("mis_id_inst", id_inst, NOP_INST);
    r0 = req_cnt;
    repeat (6) @(posedge clk);
    #1 chk("mis_no_req", 32'(req_cnt - r0), 0);
    redirect(32'h0000_0500, 1'b1);
    push_path(32'h0000_0500, 4);
    wait_drain(40);
    #1 chk("mis_cleared", id_misalign, 0);
`endif

    // Table of redirect targets, memory latencies and decode stall patterns
    for (int i = 0; i < 5; i++) begin
      lat       = vt[i].lat;
      rnd_ready = vt[i].rnd;
      redirect(vt[i].tgt, 1'b1);
      push_path(vt[i].tgt, vt[i].n);
      wait_drain(20 * vt[i].n + 20);
      settle_drop();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
